// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: owns PC, IR and flags, and sequences fetch, condition check,
// execute, load/store and write-back while driving the RAM and register-bank strobes.
module cpu_sequencer #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RAM_LAT = 1,
  parameter logic [3:0]  OP_LDR  = 4'hD,
  parameter logic [3:0]  OP_STR  = 4'hE,
  parameter logic [3:0]  OP_B    = 4'hC
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ram_Enable,
  output logic              Ram_RW,
  output logic [ADDR_W-1:0] Ram_Address,
  input  logic [DATA_W-1:0] Ram_Data_in,
  output logic [DATA_W-1:0] Ram_Data_out,
  input  logic [DATA_W-1:0] Store_Data,
  input  logic [DATA_W-1:0] Alu_Result,
  input  logic [3:0]        New_Flag,
  output logic [DATA_W-1:0] Instruction,
  output logic [3:0]        Flag,
  output logic              Reg_Write,
  output logic              Reg_Src_Mem,
  output logic [ADDR_W-1:0] Pc,
  output logic              Busy,
  output logic              Halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_EXEC,
    S_MEM,
    S_MWAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [3:0]          flag_q, flag_d;
  logic [2:0]          lat_cnt_q, lat_cnt_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_rw_q, ram_rw_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_dout_q, ram_dout_d;
  logic                reg_write_q, reg_write_d;
  logic                reg_src_mem_q, reg_src_mem_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                lat_last;

  // Only the low ADDR_W bits of the ALU result form a memory address.
  logic unused_alu_hi;
  assign unused_alu_hi = ^Alu_Result[DATA_W-1:ADDR_W];

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c & !z;
      4'h9:    cond_pass = !c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    is_alu_op = (op != OP_B) && (op != OP_LDR) && (op != OP_STR);
  endfunction

  // True when the instruction, executed under the given flags, writes the ALU result back.
  function automatic logic alu_fires(input logic [DATA_W-1:0] ir, input logic [3:0] f);
    alu_fires = (ir != '1) && cond_pass(ir[31:28], f) && is_alu_op(ir[27:24]);
  endfunction

  assign lat_last = (lat_cnt_q == LAT_LAST);

  always_comb begin
    // NOTE: every _d takes a default first so no path through the case can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    flag_d        = flag_q;
    lat_cnt_d     = lat_cnt_q;
    ram_addr_d    = ram_addr_q;
    ram_dout_d    = ram_dout_q;
    ram_en_d      = 1'b0;
    ram_rw_d      = 1'b1;
    reg_write_d   = 1'b0;
    reg_src_mem_d = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        lat_cnt_d = '0;
        state_d   = S_FWAIT;
      end
      S_FWAIT: begin
        if (lat_last) begin
          ir_d    = Ram_Data_in;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (ir_q == '1) begin
          state_d = S_HALT;
        end else if (cond_pass(ir_q[31:28], flag_q)) begin
          if (ir_q[27:24] == OP_B) begin
            pc_d = ADDR_W'(ir_q[18:3]);
          end else if (ir_q[27:24] == OP_LDR || ir_q[27:24] == OP_STR) begin
            state_d = S_MEM;
          end else if (ir_q[23]) begin
            flag_d = New_Flag;
          end
        end
      end
      S_MEM: begin
        if (ir_q[27:24] == OP_STR) begin
          state_d = S_FETCH;
        end else begin
          lat_cnt_d = '0;
          state_d   = S_MWAIT;
        end
      end
      S_MWAIT: begin
        if (lat_last) begin
          state_d = S_WB;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    // The ALU operands are stable from EXEC through MEM, so sampling them here is safe.
    case (state_d)
      S_FETCH, S_FWAIT: begin
        ram_en_d   = 1'b1;
        ram_addr_d = pc_d;
      end
      S_EXEC: reg_write_d = alu_fires(ir_d, flag_d);
      S_MEM: begin
        ram_en_d   = 1'b1;
        ram_addr_d = Alu_Result[ADDR_W-1:0];
        if (ir_d[27:24] == OP_STR) begin
          ram_rw_d   = 1'b0;
          ram_dout_d = Store_Data;
        end
      end
      S_MWAIT: ram_en_d = 1'b1;
      S_WB: begin
        reg_write_d   = 1'b1;
        reg_src_mem_d = 1'b1;
      end
      default: ;
    endcase

    busy_d   = !(state_d inside {S_IDLE, S_HALT});
    halted_d = (state_d == S_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      flag_q        <= '0;
      lat_cnt_q     <= '0;
      ram_en_q      <= 1'b0;
      ram_rw_q      <= 1'b1;
      ram_addr_q    <= '0;
      ram_dout_q    <= '0;
      reg_write_q   <= 1'b0;
      reg_src_mem_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      flag_q        <= flag_d;
      lat_cnt_q     <= lat_cnt_d;
      ram_en_q      <= ram_en_d;
      ram_rw_q      <= ram_rw_d;
      ram_addr_q    <= ram_addr_d;
      ram_dout_q    <= ram_dout_d;
      reg_write_q   <= reg_write_d;
      reg_src_mem_q <= reg_src_mem_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  assign Ram_Enable   = ram_en_q;
  assign Ram_RW       = ram_rw_q;
  assign Ram_Address  = ram_addr_q;
  assign Ram_Data_out = ram_dout_q;
  assign Instruction  = ir_q;
  assign Flag         = flag_q;
  assign Reg_Write    = reg_write_q;
  assign Reg_Src_Mem  = reg_src_mem_q;
  assign Pc           = pc_q;
  assign Busy         = busy_q;
  assign Halted       = halted_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control unit for the CPU datapath (RAM, register bank, ALU, memory control). It owns the program counter (PC), the instruction register (IR) and the flag register. It sequences fetch, condition check, execute, load/store and write-back, and drives the RAM and register-bank control strobes that the bench currently applies by hand. It sits between the RAM and the decode fields: IR feeds the Cond/OpCode/S/destination/source/IV field split.

Parameters:
ADDR_W, 16, RAM address and PC width
DATA_W, 32, instruction/data width
RAM_LAT, 1, RAM read latency in cycles (1..7)
OP_LDR, 4'hD, opcode for load
OP_STR, 4'hE, opcode for store
OP_B, 4'hC, opcode for absolute branch

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  one-cycle pulse; begins execution from PC=0 when in IDLE or HALT
Ram_Enable  out  1  RAM enable
Ram_RW  out  1  1=read, 0=write
Ram_Address  out  ADDR_W  RAM address
Ram_Data_in  in  DATA_W  RAM read data (Out)
Ram_Data_out  out  DATA_W  RAM write data
Store_Data  in  DATA_W  register source_2 value for STR
Alu_Result  in  DATA_W  ALU result; low ADDR_W bits are the LDR/STR address
New_Flag  in  4  ALU flags {N,Z,C,V}
Instruction  out  DATA_W  IR contents
Flag  out  4  current flags {N,Z,C,V}
Reg_Write  out  1  one-cycle register-bank write strobe
Reg_Src_Mem  out  1  write-back source: 0=ALU, 1=RAM data
Pc  out  ADDR_W  current PC
Busy  out  1  high in all states except IDLE and HALT
Halted  out  1  high in HALT

Behaviour:
- Reset (async, Reset=0): state=IDLE, Pc=0, IR=0, Flag=0, Ram_Enable=0, Ram_RW=1, Ram_Address=0, Ram_Data_out=0, Reg_Write=0, Reg_Src_Mem=0, Busy=0, Halted=0. Reset asserted mid-instruction aborts it with no write-back and no RAM write.
- States: IDLE, FETCH, FWAIT, EXEC, MEM, MWAIT, WB, HALT.
- IDLE/HALT:
  - Start=1 sets Pc=0 and moves to FETCH.
  - Start is ignored in every other state.
- FETCH (1 cycle): Ram_Enable=1, Ram_RW=1, Ram_Address=Pc. Next state FWAIT.
- FWAIT (RAM_LAT cycles, internal counter):
  - Enable and address are held.
  - On the last cycle: IR<=Ram_Data_in, Pc<=Pc+1 (modulo 2^ADDR_W; wraps 0xFFFF->0). Next state EXEC.
- EXEC (1 cycle):
  - IR==all-ones: HALT. This check overrides the condition check.
  - Otherwise evaluate Cond=IR[31:28] against Flag:
    - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
    - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
    - E AL always; F NV never
  - Condition false: no side effects, next state FETCH.
  - Condition true, by OpCode=IR[27:24]:
    - OP_B: Pc<=IR[18:3] truncated/zero-extended to ADDR_W; next FETCH.
    - OP_LDR: next MEM (read).
    - OP_STR: next MEM (write).
    - Any other opcode (ALU op): Reg_Write=1, Reg_Src_Mem=0 this cycle; if S=IR[23]=1, Flag<=New_Flag; next FETCH.
- MEM (1 cycle): Ram_Enable=1, Ram_Address=Alu_Result[ADDR_W-1:0].
  - STR: Ram_RW=0, Ram_Data_out=Store_Data; next FETCH.
  - LDR: Ram_RW=1; next MWAIT.
- MWAIT (RAM_LAT cycles): read held; next WB.
- WB (1 cycle): Reg_Write=1, Reg_Src_Mem=1; next FETCH.
- Ram_Enable=0 and Ram_RW=1 in all other states. Flags are never changed by LDR, STR or B.
- Cycle counts at RAM_LAT=1: ALU op/B/skipped = 3, STR = 4, LDR = 6.
- Reg_Write is never asserted outside EXEC (ALU op) or WB.

Test Plan:
- Reset during an LDR's MWAIT, then release -> IDLE, Pc=0, no Reg_Write, Ram_Enable=0; Start -> fetch from address 0.
- Program at 0..2: ALU AL S=1 (New_Flag=0100), then EQ ALU, then NE ALU -> Flag=0100; Reg_Write pulses at cycles 3 and 6, none for NE; Pc=3 after 9 cycles.
- STR AL with Alu_Result=0x0020, Store_Data=0xDEADBEEF -> exactly one cycle with Ram_Enable=1, Ram_RW=0, Ram_Address=0x0020, Ram_Data_out=0xDEADBEEF.
- LDR AL with RAM_LAT=3, Alu_Result=0x0005 -> read held 4 cycles at 0x0005, then one-cycle Reg_Write with Reg_Src_Mem=1; total 10 cycles.
- B AL to 0x0007, where address 7 holds 0xFFFFFFFF -> Pc=7, then Halted=1, Busy=0; Start -> Pc=0, Busy=1.
- Pc=0xFFFF fetch of an ALU op -> Pc wraps to 0x0000.
